// File: rtl/des_pkg.sv
// Shared DES sequencing constants: round count, state encoding and the key shift schedule.
package des_pkg;

    localparam int unsigned DES_ROUNDS  = 16;
    localparam int unsigned ROUND_IDX_W = 4;

    // Bit i set when round i+1 rotates the key halves by one position (rounds 1, 2, 9, 16).
    localparam logic [DES_ROUNDS-1:0] SINGLE_SHIFT_MASK = 16'b1000_0001_0000_0011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2
    } state_e;

    function automatic logic is_double_shift(input logic [ROUND_IDX_W-1:0] round_index);
        return ~SINGLE_SHIFT_MASK[round_index];
    endfunction

endpackage

// File: rtl/des_round_controller_if.sv
// Request-side and key/round-datapath control signals of the DES round controller.
interface des_round_controller_if;
    import des_pkg::*;

    logic                   start_din;
    logic                   hold_din;
    logic                   ready_dout;
    logic                   key_enable_dout;
    logic                   key_source_sel_dout;
    logic                   key_round_shift_dout;
    logic                   round_valid_dout;
    logic [ROUND_IDX_W-1:0] round_index_dout;
    logic                   first_round_dout;
    logic                   last_round_dout;
    logic                   done_dout;

    modport slave (
        input  start_din, hold_din,
        output ready_dout, key_enable_dout, key_source_sel_dout, key_round_shift_dout,
               round_valid_dout, round_index_dout, first_round_dout, last_round_dout, done_dout
    );

    modport master (
        output start_din, hold_din,
        input  ready_dout, key_enable_dout, key_source_sel_dout, key_round_shift_dout,
               round_valid_dout, round_index_dout, first_round_dout, last_round_dout, done_dout
    );

endinterface

// File: rtl/des_shift_schedule.sv
// Maps a round index to the key rotate amount (0 = rotate by 1, 1 = rotate by 2).
module des_shift_schedule
    import des_pkg::*;
(
    input  logic [ROUND_IDX_W-1:0] round_index_din,
    output logic                   round_shift_dout
);

    assign round_shift_dout = is_double_shift(round_index_din);

endmodule

// File: rtl/des_round_controller.sv
// Sequences one key-load cycle and the 16 DES rounds, driving key generator and round datapath controls.
module des_round_controller
    import des_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    des_round_controller_if.slave  bus
);

    localparam logic [ROUND_IDX_W-1:0] LAST_IDX = ROUND_IDX_W'(DES_ROUNDS - 1);

    state_e                 state_q, state_d;
    logic [ROUND_IDX_W-1:0] cnt_q, cnt_d;
    logic                   sched_shift;

    logic                   ready;
    logic                   key_enable;
    logic                   key_source_sel;
    logic                   key_round_shift;
    logic                   round_valid;
    logic [ROUND_IDX_W-1:0] round_index;
    logic                   first_round;
    logic                   last_round;
    logic                   done;

    des_shift_schedule u_shift_schedule (
        .round_index_din  (cnt_q),
        .round_shift_dout (sched_shift)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and output decode; hold only reaches the enable/valid/done outputs.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        ready           = 1'b0;
        key_enable      = 1'b0;
        key_source_sel  = 1'b0;
        key_round_shift = 1'b0;
        round_valid     = 1'b0;
        round_index     = '0;
        first_round     = 1'b0;
        last_round      = 1'b0;
        done            = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.start_din) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                key_enable = ~bus.hold_din;
                if (!bus.hold_din) begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                key_source_sel  = 1'b1;
                key_enable      = ~bus.hold_din;
                round_valid     = ~bus.hold_din;
                key_round_shift = sched_shift;
                round_index     = cnt_q;
                first_round     = (cnt_q == '0);
                last_round      = (cnt_q == LAST_IDX);
                done            = last_round & round_valid;
                if (!bus.hold_din) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ROUND_IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.ready_dout           = ready;
    assign bus.key_enable_dout      = key_enable;
    assign bus.key_source_sel_dout  = key_source_sel;
    assign bus.key_round_shift_dout = key_round_shift;
    assign bus.round_valid_dout     = round_valid;
    assign bus.round_index_dout     = round_index;
    assign bus.first_round_dout     = first_round;
    assign bus.last_round_dout      = last_round;
    assign bus.done_dout            = done;

endmodule

// File: tb/tb_des_round_controller.sv
// Scoreboard bench for des_round_controller with a behavioural DES key generator attached.
module tb_des_round_controller;
    import des_pkg::*;

    typedef struct {
        logic [3:0]  idx;
        logic        shift;
        logic        first;
        logic        last;
        logic [47:0] key;
        bit          chk_key;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    int pc1_t [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
                       10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                       63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                       14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
    int pc2_t [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,
                       23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                       41,52,31,37,47,55,30,40,51,45,33,48,
                       44,49,39,56,34,53,46,42,50,36,29,32};
    int shift_t [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    logic [63:0] des_key = 64'h1334_5779_9BBC_DFF1;
    logic [47:0] k1_ref  = 48'h1B02_EFFC_7072;
    logic [47:0] k16_ref = 48'hCB3D_8B0E_17F5;
    logic [55:0] cd_q;

    des_round_controller_if bus();

    des_round_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [55:0] pc1_f(input logic [63:0] k);
        logic [55:0] r;
        for (int j = 0; j < 56; j++) r[55-j] = k[64-pc1_t[j]];
        return r;
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] cd);
        logic [47:0] r;
        for (int j = 0; j < 48; j++) r[47-j] = cd[56-pc2_t[j]];
        return r;
    endfunction

    function automatic logic [55:0] rot_f(input logic [55:0] cd, input logic two);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[55:28];
        d = cd[27:0];
        if (two) begin
            c = {c[25:0], c[27:26]};
            d = {d[25:0], d[27:26]};
        end else begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        return {c, d};
    endfunction

    // Key generator model: loads PC1 on source 0, stores the rotated halves on source 1.
    always @(posedge clk) begin
        if (bus.key_enable_dout) begin
            cd_q <= bus.key_source_sel_dout ? rot_f(cd_q, bus.key_round_shift_dout) : pc1_f(des_key);
        end
    end

    // Expected per-round results of one full operation.
    function automatic void push_op();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.idx     = 4'(i);
            e.shift   = (shift_t[i] == 2);
            e.first   = (i == 0);
            e.last    = (i == 15);
            e.key     = (i == 0) ? k1_ref : k16_ref;
            e.chk_key = (i == 0) || (i == 15);
            sb.push_back(e);
        end
    endfunction

    // Scoreboard consumer: one entry per valid round cycle.
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [47:0] rk;
        if (bus.round_valid_dout) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_round: got idx %0d, expected no round", bus.round_index_dout);
            end else begin
                e = sb.pop_front();
                if ({bus.round_index_dout, bus.key_round_shift_dout, bus.first_round_dout,
                     bus.last_round_dout, bus.done_dout} !== {e.idx, e.shift, e.first, e.last, e.last}) begin
                    n_fail++;
                    $display("FAIL sb_round: got idx=%0d shift=%b first=%b last=%b done=%b, expected idx=%0d shift=%b first=%b last=%b done=%b",
                             bus.round_index_dout, bus.key_round_shift_dout, bus.first_round_dout,
                             bus.last_round_dout, bus.done_dout, e.idx, e.shift, e.first, e.last, e.last);
                end
                if (e.chk_key) begin
                    n_cmp++;
                    rk = pc2_f(rot_f(cd_q, bus.key_round_shift_dout));
                    if (rk !== e.key) begin
                        n_fail++;
                        $display("FAIL sb_round_key idx %0d: got %h expected %h", e.idx, rk, e.key);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start_din = 1'b0;
        bus.hold_din  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.ready_dout !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", bus.ready_dout);
        end
        n_cmp++;
        if ({bus.key_enable_dout, bus.key_source_sel_dout, bus.key_round_shift_dout, bus.round_valid_dout,
             bus.first_round_dout, bus.last_round_dout, bus.done_dout, bus.round_index_dout} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0", {bus.key_enable_dout, bus.key_source_sel_dout,
                     bus.key_round_shift_dout, bus.round_valid_dout, bus.first_round_dout,
                     bus.last_round_dout, bus.done_dout, bus.round_index_dout});
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_nominal();
        int done_cyc = -1;
        push_op();
        tick();
        bus.start_din = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.ready_dout !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_ready_c0: got %b expected 1", bus.ready_dout);
        end
        tick();
        bus.start_din = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.ready_dout, bus.key_enable_dout, bus.key_source_sel_dout, bus.round_valid_dout} !== 4'b0100) begin
            n_fail++;
            $display("FAIL nominal_load_c1: got rdy/en/sel/vld=%b expected 0100",
                     {bus.ready_dout, bus.key_enable_dout, bus.key_source_sel_dout, bus.round_valid_dout});
        end
        for (int c = 2; c <= 18; c++) begin
            tick();
            @(negedge clk);
            if (bus.done_dout === 1'b1 && done_cyc < 0) done_cyc = c;
            if (c == 18) begin
                n_cmp++;
                if (bus.ready_dout !== 1'b1) begin
                    n_fail++;
                    $display("FAIL nominal_ready_c18: got %b expected 1", bus.ready_dout);
                end
            end
        end
        n_cmp++;
        if (done_cyc !== 17) begin
            n_fail++;
            $display("FAIL nominal_done_cycle: got %0d expected 17", done_cyc);
        end
    endtask

    task automatic test_hold();
        int done_cyc = -1;
        push_op();
        tick();
        bus.start_din = 1'b1;
        @(negedge clk);
        tick();
        bus.start_din = 1'b0;
        @(negedge clk);
        for (int c = 2; c <= 21; c++) begin
            tick();
            bus.hold_din = (c >= 6 && c <= 8);
            @(negedge clk);
            if (bus.done_dout === 1'b1 && done_cyc < 0) done_cyc = c;
            if (c >= 6 && c <= 8) begin
                n_cmp++;
                if ({bus.key_enable_dout, bus.round_valid_dout, bus.round_index_dout,
                     bus.key_round_shift_dout} !== {2'b00, 4'd4, 1'b1}) begin
                    n_fail++;
                    $display("FAIL hold_c%0d: got en/vld/idx/shift=%b expected 0001001", c,
                             {bus.key_enable_dout, bus.round_valid_dout, bus.round_index_dout,
                              bus.key_round_shift_dout});
                end
            end
        end
        bus.hold_din = 1'b0;
        n_cmp++;
        if (done_cyc !== 20) begin
            n_fail++;
            $display("FAIL hold_done_cycle: got %0d expected 20", done_cyc);
        end
        n_cmp++;
        if (bus.ready_dout !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_ready_c21: got %b expected 1", bus.ready_dout);
        end
    endtask

    task automatic test_ignored_start();
        int n_done = 0;
        push_op();
        tick();
        bus.start_din = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 30; c++) begin
            tick();
            bus.start_din = (c == 8 || c == 17);
            @(negedge clk);
            if (bus.done_dout === 1'b1) n_done++;
            if (c == 19) begin
                n_cmp++;
                if ({bus.ready_dout, bus.key_enable_dout} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL ignored_idle_c19: got rdy/en=%b expected 10",
                             {bus.ready_dout, bus.key_enable_dout});
                end
            end
        end
        bus.start_din = 1'b0;
        n_cmp++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL ignored_done_count: got %0d expected 1", n_done);
        end
    endtask

    task automatic test_async_reset();
        int n_done   = 0;
        int done_cyc = -1;
        push_op();
        tick();
        bus.start_din = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 11; c++) begin
            tick();
            bus.start_din = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (bus.round_index_dout !== 4'd9) begin
            n_fail++;
            $display("FAIL areset_pre_idx: got %0d expected 9", bus.round_index_dout);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.ready_dout, bus.key_enable_dout, bus.key_source_sel_dout, bus.key_round_shift_dout,
             bus.round_valid_dout, bus.first_round_dout, bus.last_round_dout, bus.done_dout,
             bus.round_index_dout} !== {1'b1, 11'd0}) begin
            n_fail++;
            $display("FAIL areset_outputs: got %b expected 100000000000",
                     {bus.ready_dout, bus.key_enable_dout, bus.key_source_sel_dout, bus.key_round_shift_dout,
                      bus.round_valid_dout, bus.first_round_dout, bus.last_round_dout, bus.done_dout,
                      bus.round_index_dout});
        end
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done_dout === 1'b1) n_done++;
        end
        n_cmp++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL areset_no_done: got %0d expected 0", n_done);
        end
        push_op();
        tick();
        bus.start_din = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 18; c++) begin
            tick();
            bus.start_din = 1'b0;
            @(negedge clk);
            if (bus.done_dout === 1'b1 && done_cyc < 0) done_cyc = c;
        end
        n_cmp++;
        if (done_cyc !== 17) begin
            n_fail++;
            $display("FAIL areset_rerun_done: got %0d expected 17", done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        int dones [3] = '{-1, -1, -1};
        int nd = 0;
        push_op();
        push_op();
        push_op();
        tick();
        bus.start_din = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 56; c++) begin
            tick();
            if (c == 40) bus.start_din = 1'b0;
            @(negedge clk);
            if (bus.done_dout === 1'b1) begin
                if (nd < 3) dones[nd] = c;
                nd++;
            end
            if (c == 18 || c == 19) begin
                n_cmp++;
                if ({bus.ready_dout, bus.key_enable_dout} !== ((c == 18) ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL b2b_relaunch_c%0d: got rdy/en=%b expected %b", c,
                             {bus.ready_dout, bus.key_enable_dout}, (c == 18) ? 2'b10 : 2'b01);
                end
            end
        end
        n_cmp++;
        if (nd !== 3 || dones[0] !== 17 || dones[1] !== 35 || dones[2] !== 53) begin
            n_fail++;
            $display("FAIL b2b_done_cycles: got n=%0d at %0d,%0d,%0d expected n=3 at 17,35,53",
                     nd, dones[0], dones[1], dones[2]);
        end
        n_cmp++;
        if (bus.ready_dout !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_end: got %b expected 1", bus.ready_dout);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_hold();
        test_ignored_start();
        test_async_reset();
        test_back_to_back();
        n_cmp++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
